// File: rtl/music_player_mix_if.sv
// Bus bundle between the music player core and its surroundings.
// The vol signal exists only when MUSIC_PLAYER_VOLUME_EN is defined.
interface music_player_mix_if #(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned SONG_W     = 2
);
  logic                           play_pause;
  logic                           next;
  logic                           prev;
  logic                           song_done;
  logic                           NewFrame;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
`ifdef MUSIC_PLAYER_VOLUME_EN
  logic [2:0]                     vol;
`endif
  logic                           ready;
  logic                           beat;
  logic                           play;
  logic [SONG_W-1:0]              song;
  logic                           reset_play;
  logic [SAMPLE_W-1:0]            sample;
  logic                           sample_valid;

  modport master (
    output play_pause, next, prev, song_done, NewFrame, voice_sample,
`ifdef MUSIC_PLAYER_VOLUME_EN
    output vol,
`endif
    input  ready, beat, play, song, reset_play, sample, sample_valid
  );

  modport slave (
    input  play_pause, next, prev, song_done, NewFrame, voice_sample,
`ifdef MUSIC_PLAYER_VOLUME_EN
    input  vol,
`endif
    output ready, beat, play, song, reset_play, sample, sample_valid
  );
endinterface

// File: rtl/music_player_mix.sv
// Music player core: frame synchroniser, beat generator, transport FSM and saturating voice mixer.
// Optional MUSIC_PLAYER_VOLUME_EN adds a vol input that right-shifts the mix before saturation.
module music_player_mix #(
  parameter int unsigned NUM_SONGS  = 4,
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned BEAT_DIV   = 1000,
  parameter int unsigned SONG_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  music_player_mix_if.slave bus
);
  localparam int unsigned SUM_W = SAMPLE_W + 3;
  localparam int unsigned CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEAT_DIV - 1);

  typedef enum logic [1:0] {RST, PAUSED, PLAY, STEP} state_t;

  state_t                   state, state_d;
  logic                     s1, s2, ready_d;
  logic [CNT_W-1:0]         count, count_d;
  logic [SONG_W-1:0]        song_d;
  logic                     resume, resume_d;
  logic                     dir_up, dir_up_d;
  logic signed [SUM_W-1:0]  sum_c, shifted_c;
  logic [SAMPLE_W-1:0]      sat_c;

  // Two flops of synchronisation; the ready flop doubles as the edge-detect third stage.
  assign ready_d = s1 & ~s2;

  always_comb begin
    count_d = count;
    if (bus.reset_play)
      count_d = '0;
    else if (bus.ready)
      count_d = (count == LAST_CNT) ? '0 : count + CNT_W'(1);
  end

  // beat is registered with look-ahead so it coincides with the ready it counts
  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      bus.ready <= 1'b0;
      bus.beat  <= 1'b0;
      count     <= '0;
    end else begin
      s1        <= bus.NewFrame;
      s2        <= s1;
      bus.ready <= ready_d;
      bus.beat  <= ready_d && (count_d == LAST_CNT);
      count     <= count_d;
    end
  end

  // Transport FSM: next > prev > song_done > play_pause, inputs ignored in STEP/RST
  always_comb begin
    state_d  = state;
    song_d   = bus.song;
    resume_d = resume;
    dir_up_d = dir_up;
    case (state)
      RST: state_d = resume ? PLAY : PAUSED;
      PAUSED: begin
        if (bus.next) begin
          state_d = STEP; dir_up_d = 1'b1; resume_d = 1'b0;
        end else if (bus.prev) begin
          state_d = STEP; dir_up_d = 1'b0; resume_d = 1'b0;
        end else if (bus.play_pause) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (bus.next) begin
          state_d = STEP; dir_up_d = 1'b1; resume_d = 1'b0;
        end else if (bus.prev) begin
          state_d = STEP; dir_up_d = 1'b0; resume_d = 1'b0;
        end else if (bus.song_done) begin
          state_d = STEP; dir_up_d = 1'b1; resume_d = 1'b1;
        end else if (bus.play_pause) begin
          state_d = PAUSED;
        end
      end
      STEP: begin
        if (dir_up)
          song_d = (bus.song == LAST_SONG) ? '0 : bus.song + SONG_W'(1);
        else
          song_d = (bus.song == '0) ? LAST_SONG : bus.song - SONG_W'(1);
        state_d = RST;
      end
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RST;
      bus.song       <= '0;
      resume         <= 1'b0;
      dir_up         <= 1'b1;
      bus.play       <= 1'b0;
      bus.reset_play <= 1'b1;
    end else begin
      state          <= state_d;
      bus.song       <= song_d;
      resume         <= resume_d;
      dir_up         <= dir_up_d;
      bus.play       <= (state_d == PLAY);
      bus.reset_play <= (state_d == RST);
    end
  end

  // Mixer: sign-extended sum, optional attenuation, then clamp to the sample range
  always_comb begin
    sum_c = '0;
    if (bus.play) begin
      for (int i = 0; i < NUM_VOICES; i++)
        sum_c = sum_c + SUM_W'($signed(bus.voice_sample[i*SAMPLE_W +: SAMPLE_W]));
    end
`ifdef MUSIC_PLAYER_VOLUME_EN
    shifted_c = sum_c >>> bus.vol;
`else
    shifted_c = sum_c;
`endif
    if ((shifted_c[SUM_W-1:SAMPLE_W-1] == '0) || (shifted_c[SUM_W-1:SAMPLE_W-1] == '1))
      sat_c = shifted_c[SAMPLE_W-1:0];
    else
      sat_c = {shifted_c[SUM_W-1], {(SAMPLE_W-1){~shifted_c[SUM_W-1]}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= bus.ready;
      if (bus.ready)
        bus.sample <= sat_c;
    end
  end
endmodule

// File: tb/tb_music_player_mix.sv
// Self-checking bench for music_player_mix: directed steps plus randomized transport/mix traffic
// compared against an arithmetic reference model.
module tb_music_player_mix;
  localparam int unsigned NUM_SONGS  = 4;
  localparam int unsigned NUM_VOICES = 2;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned BEAT_DIV   = 4;
  localparam int unsigned SONG_W     = 2;
  localparam int unsigned VW         = NUM_VOICES * SAMPLE_W;
  localparam int          SMAX       = (1 <<< (SAMPLE_W - 1)) - 1;
  localparam int          SMIN       = -(1 <<< (SAMPLE_W - 1));

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   model_song = 0;
  bit   model_play = 1'b0;
  int   cur_vol    = 0;
  bit   last_beat  = 1'b0;

  music_player_mix_if #(.NUM_VOICES(NUM_VOICES), .SAMPLE_W(SAMPLE_W), .SONG_W(SONG_W)) bus ();

  music_player_mix #(
    .NUM_SONGS(NUM_SONGS), .NUM_VOICES(NUM_VOICES), .SAMPLE_W(SAMPLE_W),
    .BEAT_DIV(BEAT_DIV), .SONG_W(SONG_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference mix: integer sum, zero when paused, arithmetic shift, clamp.
  function automatic logic [SAMPLE_W-1:0] mix_model(input logic [VW-1:0] vs, input bit playing,
                                                    input int sh);
    int s = 0;
    if (playing)
      for (int i = 0; i < NUM_VOICES; i++) s += int'($signed(vs[i*SAMPLE_W +: SAMPLE_W]));
    s = s >>> sh;
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    return SAMPLE_W'(s);
  endfunction

  function automatic logic [SAMPLE_W-1:0] rand_voice(input bit big);
    if (!big) return SAMPLE_W'($urandom);
    if ($urandom_range(0, 1) == 1) return SAMPLE_W'(16'h6000 + 16'($urandom_range(0, 8191)));
    return SAMPLE_W'(16'h9FFF - 16'($urandom_range(0, 8191)));
  endfunction

  // Raise NewFrame until ready appears (bounded), then move to the cycle after ready.
  task automatic frame(output bit got);
    got = 1'b0;
    last_beat = 1'b0;
    bus.NewFrame = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step(1);
      if (bus.ready === 1'b1) begin
        got = 1'b1;
        last_beat = bus.beat;
      end
    end
    bus.NewFrame = 1'b0;
    if (got) step(1);
  endtask

  task automatic mix_frame(input string tag, input logic [VW-1:0] vs, input logic [SAMPLE_W-1:0] exp);
    bit got;
    bus.voice_sample = vs;
    frame(got);
    check({tag, "_ready"}, 32'(got), 32'd1);
    check({tag, "_valid"}, 32'(bus.sample_valid), 32'd1);
    check(tag, 32'(bus.sample), 32'(exp));
    step(3);
    check({tag, "_hold"}, 32'(bus.sample), 32'(exp));
    check({tag, "_valid_low"}, 32'(bus.sample_valid), 32'd0);
  endtask

  // Apply one command pulse, advance the model by the transport rules, check the settled state.
  task automatic cmd(input bit nx, input bit pv, input bit sd, input bit pp);
    bit stepped = 1'b0;
    if (nx) begin
      model_song = (model_song + 1) % NUM_SONGS; model_play = 1'b0; stepped = 1'b1;
    end else if (pv) begin
      model_song = (model_song + NUM_SONGS - 1) % NUM_SONGS; model_play = 1'b0; stepped = 1'b1;
    end else if (sd && model_play) begin
      model_song = (model_song + 1) % NUM_SONGS; stepped = 1'b1;
    end else if (pp) begin
      model_play = !model_play;
    end
    bus.next = nx; bus.prev = pv; bus.song_done = sd; bus.play_pause = pp;
    step(1);
    bus.next = 1'b0; bus.prev = 1'b0; bus.song_done = 1'b0; bus.play_pause = 1'b0;
    if (stepped) begin
      step(1);
      check("cmd_reset_play_pulse", 32'(bus.reset_play), 32'd1);
      check("cmd_song_in_rst", 32'(bus.song), 32'(model_song));
      step(1);
    end
    check("cmd_reset_play_low", 32'(bus.reset_play), 32'd0);
    check("cmd_song", 32'(bus.song), 32'(model_song));
    check("cmd_play", 32'(bus.play), 32'(model_play));
    step(1);
  endtask

  initial begin
    bit got;
    int n_ready;
    logic [VW-1:0] vs;
    bit nx, pv, sd, pp;

    reset = 1'b1;
    bus.play_pause = 1'b0; bus.next = 1'b0; bus.prev = 1'b0; bus.song_done = 1'b0;
    bus.NewFrame = 1'b0; bus.voice_sample = '0;
`ifdef MUSIC_PLAYER_VOLUME_EN
    bus.vol = 3'd0;
`endif
    step(3);
    check("rst_reset_play", 32'(bus.reset_play), 32'd1);
    check("rst_play", 32'(bus.play), 32'd0);
    check("rst_song", 32'(bus.song), 32'd0);
    check("rst_sample", 32'(bus.sample), 32'd0);
    check("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_beat", 32'(bus.beat), 32'd0);
    reset = 1'b0;
    step(1);
    check("post_rst_reset_play", 32'(bus.reset_play), 32'd0);
    check("post_rst_play", 32'(bus.play), 32'd0);
    step(2);

    // Beat every BEAT_DIV ready pulses; mixer output is zero while paused.
    bus.voice_sample = {16'h1234, 16'h0567};
    for (int n = 1; n <= 8; n++) begin
      frame(got);
      check("beat_ready", 32'(got), 32'd1);
      check("beat_flag", 32'(last_beat), 32'((n % BEAT_DIV) == 0));
      check("paused_sample", 32'(bus.sample), 32'd0);
      check("paused_valid", 32'(bus.sample_valid), 32'd1);
      step(3);
    end

    // NewFrame held high yields a single ready.
    n_ready = 0;
    bus.NewFrame = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.ready === 1'b1) n_ready++;
    end
    bus.NewFrame = 1'b0;
    step(3);
    check("held_newframe_ready_count", 32'(n_ready), 32'd1);

    // Transport directed steps.
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("song_after_next2", 32'(bus.song), 32'd1);
    cmd(1'b1, 1'b0, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("play_at_song3", 32'(bus.play), 32'd1);

    // song_done wraps and resumes; play_pause during STEP/RST is ignored.
    bus.song_done = 1'b1;
    step(1);
    bus.song_done = 1'b0;
    bus.play_pause = 1'b1;
    step(1);
    check("done_reset_play", 32'(bus.reset_play), 32'd1);
    check("done_song_wrap", 32'(bus.song), 32'd0);
    step(1);
    bus.play_pause = 1'b0;
    check("done_resume_play", 32'(bus.play), 32'd1);
    check("done_reset_play_low", 32'(bus.reset_play), 32'd0);
    step(2);
    check("done_still_play", 32'(bus.play), 32'd1);
    model_song = 0;
    model_play = 1'b1;

    // Mixer saturation corners while playing.
    mix_frame("mix_pos_sat", {16'h7000, 16'h7000}, 16'h7FFF);
    mix_frame("mix_neg_sat", {16'h8000, 16'h8000}, 16'h8000);
    mix_frame("mix_cancel", {16'hFF00, 16'h0100}, 16'h0000);
`ifdef MUSIC_PLAYER_VOLUME_EN
    bus.vol = 3'd2;
    mix_frame("mix_vol2", {16'h0400, 16'h0400}, 16'h0200);
    bus.vol = 3'd0;
    mix_frame("mix_vol0", {16'h0400, 16'h0400}, 16'h0800);
`endif

    // Random transport commands interleaved with random mixes.
    for (int it = 0; it < 24; it++) begin
      nx = ($urandom_range(0, 3) == 0);
      pv = ($urandom_range(0, 3) == 0);
      sd = model_play && ($urandom_range(0, 2) == 0);
      pp = ($urandom_range(0, 1) == 1);
      cmd(nx, pv, sd, pp);
      for (int v = 0; v < NUM_VOICES; v++)
        vs[v*SAMPLE_W +: SAMPLE_W] = rand_voice(it % 2 == 1);
`ifdef MUSIC_PLAYER_VOLUME_EN
      cur_vol = int'($urandom_range(0, 7));
      bus.vol = 3'(cur_vol);
`endif
      mix_frame("rand_mix", vs, mix_model(vs, model_play, cur_vol));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
